iwdg_feeder: RTL and testbench
==============================

IWDG_FEEDER -- requirements
Module: iwdg_feeder

Interface
REQ-001 SHALL provide parameters: BASE_ADR, default 32'h0100_0000, watchdog register base; GRL, default 1, select width minus one; REFRESH_W, default 16, refresh counter width; TIMEOUT, default 15, max cycles awaiting response.
REQ-002 SHALL provide ports: clk_m2s  in  1  single clock, all logic on rising edge.
REQ-003 rst_m2s  in  1  reset, asynchronous, active-low.
REQ-004 start  in  1  one-cycle pulse, begin configure and refresh sequence.
REQ-005 stop  in  1  one-cycle pulse, end refreshing.
REQ-006 pr_cfg  in  3  prescaler code written to PR.
REQ-007 refresh_period  in  REFRESH_W  cycles between refreshes.
REQ-008 dat_s2m  in  32; ack_s2m, err_s2m, rty_s2m  in  1 each  slave responses.
REQ-009 adr_m2s  out  32; dat_m2s  out  32; sel_m2s  out  GRL+1; cyc_m2s, stb_m2s, we_m2s, lok_m2s  out  1 each; all registered.
REQ-010 running  out  1  refresh loop active; fault  out  1  sticky bus failure; last_st  out  2  last ST read value.

Function
REQ-011 FSM states SHALL be IDLE, UNLOCK, SET_PR, START_CNT, WAIT, REFRESH, READ_ST, FAULT.
REQ-012 IDLE->UNLOCK on start; UNLOCK writes 16'h5555 to BASE_ADR+0x0; SET_PR writes {29'b0,pr_cfg} to BASE_ADR+0x4; START_CNT writes 16'hCCCC to BASE_ADR+0x0; then WAIT.
REQ-013 pr_cfg SHALL be captured at start; later changes ignored until next start.
REQ-014 On WAIT entry a down-counter SHALL load refresh_period (value 0 treated as 1) and decrement each cycle; at count 1 the next state is REFRESH.
REQ-015 REFRESH writes 16'hAAAA to BASE_ADR+0x0; then READ_ST reads BASE_ADR+0xC (we_m2s=0), latches dat_s2m[1:0] into last_st on ack; then WAIT.
REQ-016 Each transfer: cyc_m2s, stb_m2s, sel_m2s all-ones and adr/dat/we driven from the cycle after state entry, held stable until ack_s2m, err_s2m or rty_s2m sampled high.
REQ-017 After any response cyc_m2s and stb_m2s SHALL drop for at least one cycle before the next transfer.
REQ-018 lok_m2s SHALL be 1 for UNLOCK, SET_PR, START_CNT transfers, 0 otherwise.
REQ-019 rty_s2m: same transfer retried after the idle cycle; 4th consecutive rty SHALL go to FAULT.
REQ-020 err_s2m, or no response within TIMEOUT cycles of stb_m2s assertion, SHALL go to FAULT; ack and err same cycle treated as err.
REQ-021 FAULT: bus outputs idle, fault=1, running=0; start clears fault and enters UNLOCK.
REQ-022 running SHALL be 1 in WAIT, REFRESH, READ_ST, 0 otherwise.
REQ-023 stop SHALL be latched in any state except IDLE/FAULT; honored on WAIT entry or in WAIT by going to IDLE without a further transfer; latch cleared in IDLE.
REQ-024 stop and counter expiry in the same cycle: stop wins.
REQ-025 start while not IDLE/FAULT SHALL be ignored.
REQ-026 Transfers in progress SHALL never be aborted except by reset.

Reset
REQ-027 While rst_m2s=0: state IDLE, cyc/stb/we/lok=0, adr/dat=0, sel=0, running=0, fault=0, last_st=0, counters and latches cleared.
REQ-028 Reset asserted mid-transfer SHALL drop cyc_m2s/stb_m2s immediately (asynchronously).
REQ-029 Deassertion of rst_m2s SHALL be safe to synchronize; first state change no earlier than the first clock edge after deassertion.

Verification
REQ-030 start, pr_cfg=3, slave acks 1 cycle after stb -> writes 0x5555@+0x0, 0x3@+0x4, 0xCCCC@+0x0 in order, lok=1 each, one idle cycle between, running=1.
REQ-031 refresh_period=10, slave ST=2'b01 -> 0xAAAA@+0x0 then read @+0xC every cycle-counted period, last_st=1.
REQ-032 rty on UNLOCK 3 times then ack -> sequence completes, fault=0; rty 4 times -> fault=1, bus idle.
REQ-033 no ack for 15 cycles after stb -> FAULT; next start -> fault=0, UNLOCK reissued.
REQ-034 stop during REFRESH -> READ_ST completes, then IDLE, running=0, no further writes; stop coincident with expiry -> no REFRESH.
REQ-035 rst_m2s low during SET_PR transfer -> cyc_m2s=0 same cycle, all outputs reset values.

Source files
------------

// File: rtl/iwdg_feeder.sv
// Independent-watchdog feeder: unlocks and configures the IWDG over a Wishbone-style bus,
// then periodically refreshes it and reads back its status register until stopped.
`timescale 1ns/1ps
module iwdg_feeder #(
    parameter logic [31:0] BASE_ADR  = 32'h0100_0000,
    parameter int          GRL       = 1,
    parameter int          REFRESH_W = 16,
    parameter int          TIMEOUT   = 15
) (
    input  logic                 clk_m2s,
    input  logic                 rst_m2s,
    input  logic                 start,
    input  logic                 stop,
    input  logic [2:0]           pr_cfg,
    input  logic [REFRESH_W-1:0] refresh_period,
    input  logic [31:0]          dat_s2m,
    input  logic                 ack_s2m,
    input  logic                 err_s2m,
    input  logic                 rty_s2m,
    output logic [31:0]          adr_m2s,
    output logic [31:0]          dat_m2s,
    output logic [GRL:0]         sel_m2s,
    output logic                 cyc_m2s,
    output logic                 stb_m2s,
    output logic                 we_m2s,
    output logic                 lok_m2s,
    output logic                 running,
    output logic                 fault,
    output logic [1:0]           last_st
);

    localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, UNLOCK, SET_PR, START_CNT, WAIT, REFRESH, READ_ST, FAULT
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [31:0]          r_adr, r_dat, w_adr, w_dat;
    logic [GRL:0]         r_sel;
    logic                 r_cyc, r_we, r_lok, w_we, w_lok, w_xfer;
    logic [TMO_W-1:0]     r_tmo;
    logic [1:0]           r_rty;
    logic [REFRESH_W-1:0] r_cnt;
    logic [2:0]           r_pr;
    logic                 r_stop, r_running, r_fault;
    logic [1:0]           r_last_st;
    logic                 w_ack, w_err, w_rty, w_tmo, w_resp, w_fail, w_launch, w_stop;
    logic                 w_unused;

    // Error wins over ack; a retry only counts when neither ack nor err is present.
    assign w_err    = r_cyc & err_s2m;
    assign w_ack    = r_cyc & ack_s2m & ~err_s2m;
    assign w_rty    = r_cyc & rty_s2m & ~ack_s2m & ~err_s2m;
    assign w_resp   = r_cyc & (ack_s2m | err_s2m | rty_s2m);
    assign w_tmo    = r_cyc & ~(ack_s2m | err_s2m | rty_s2m) & (r_tmo == TMO_W'(TIMEOUT - 1));
    assign w_fail   = w_err | w_tmo | (w_rty & (r_rty == 2'd3));
    assign w_launch = w_xfer & ~r_cyc;
    assign w_stop   = r_stop | stop;
    assign w_unused = ^dat_s2m[31:2];

    always_ff @(posedge clk_m2s or negedge rst_m2s) begin
        if (!rst_m2s) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_xfer      = 1'b0;
        w_adr       = BASE_ADR;
        w_dat       = 32'h0;
        w_we        = 1'b0;
        w_lok       = 1'b0;
        case (r_state)
            UNLOCK:    begin w_xfer = 1'b1; w_dat = 32'h5555; w_we = 1'b1; w_lok = 1'b1; end
            SET_PR:    begin
                w_xfer = 1'b1; w_adr = BASE_ADR + 32'h4; w_dat = {29'b0, r_pr};
                w_we   = 1'b1; w_lok = 1'b1;
            end
            START_CNT: begin w_xfer = 1'b1; w_dat = 32'hCCCC; w_we = 1'b1; w_lok = 1'b1; end
            REFRESH:   begin w_xfer = 1'b1; w_dat = 32'hAAAA; w_we = 1'b1; end
            READ_ST:   begin w_xfer = 1'b1; w_adr = BASE_ADR + 32'hC; end
            default:   ;
        endcase
        case (r_state)
            IDLE, FAULT: if (start) w_state_nxt = UNLOCK;
            WAIT: begin
                if (w_stop)                            w_state_nxt = IDLE;
                else if (r_cnt == REFRESH_W'(1))       w_state_nxt = REFRESH;
            end
            default: begin
                if (w_fail) w_state_nxt = FAULT;
                else if (w_ack) begin
                    case (r_state)
                        UNLOCK:  w_state_nxt = SET_PR;
                        SET_PR:  w_state_nxt = START_CNT;
                        REFRESH: w_state_nxt = READ_ST;
                        default: w_state_nxt = w_stop ? IDLE : WAIT;
                    endcase
                end
            end
        endcase
    end

    // Bus registers: launch on the first idle cycle of a transfer state, clear on any response.
    always_ff @(posedge clk_m2s or negedge rst_m2s) begin
        if (!rst_m2s) begin
            r_cyc <= 1'b0; r_adr <= '0; r_dat <= '0; r_sel <= '0; r_we <= 1'b0; r_lok <= 1'b0;
            r_tmo <= '0;
        end else if (w_launch) begin
            r_cyc <= 1'b1; r_adr <= w_adr; r_dat <= w_dat; r_sel <= '1; r_we <= w_we; r_lok <= w_lok;
            r_tmo <= '0;
        end else if (w_resp || w_tmo) begin
            r_cyc <= 1'b0; r_adr <= '0; r_dat <= '0; r_sel <= '0; r_we <= 1'b0; r_lok <= 1'b0;
        end else if (r_cyc) begin
            r_tmo <= r_tmo + TMO_W'(1);
        end
    end

    always_ff @(posedge clk_m2s or negedge rst_m2s) begin
        if (!rst_m2s) begin
            r_rty <= '0; r_cnt <= '0; r_pr <= '0; r_stop <= 1'b0;
            r_running <= 1'b0; r_fault <= 1'b0; r_last_st <= '0;
        end else begin
            if (w_state_nxt != r_state) r_rty <= '0;
            else if (w_rty)             r_rty <= r_rty + 2'd1;

            if (r_state != WAIT && w_state_nxt == WAIT)
                r_cnt <= (refresh_period == '0) ? REFRESH_W'(1) : refresh_period;
            else if (r_state == WAIT)
                r_cnt <= r_cnt - REFRESH_W'(1);

            if ((r_state == IDLE || r_state == FAULT) && start) r_pr <= pr_cfg;

            if (r_state == IDLE || r_state == FAULT) r_stop <= 1'b0;
            else if (stop)                           r_stop <= 1'b1;

            r_running <= (w_state_nxt == WAIT) || (w_state_nxt == REFRESH) || (w_state_nxt == READ_ST);
            r_fault   <= (w_state_nxt == FAULT);

            if (r_state == READ_ST && w_ack) r_last_st <= dat_s2m[1:0];
        end
    end

    assign adr_m2s = r_adr;
    assign dat_m2s = r_dat;
    assign sel_m2s = r_sel;
    assign cyc_m2s = r_cyc;
    assign stb_m2s = r_cyc;
    assign we_m2s  = r_we;
    assign lok_m2s = r_lok;
    assign running = r_running;
    assign fault   = r_fault;
    assign last_st = r_last_st;

endmodule

// File: tb/tb_iwdg_feeder.sv
// Scoreboard bench for iwdg_feeder: a slave model answers bus cycles and logs every
// transfer it sees; scenario tasks queue expected transfers and compare them in order.
`timescale 1ns/1ps
module tb_iwdg_feeder;

    localparam logic [31:0] BASE = 32'h0100_0000;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic        we;
        logic        lok;
        logic [1:0]  sel;
    } xfer_t;

    logic        clk_m2s = 1'b0;
    logic        rst_m2s, start, stop;
    logic [2:0]  pr_cfg;
    logic [15:0] refresh_period;
    logic [31:0] dat_s2m;
    logic        ack_s2m, err_s2m, rty_s2m;
    logic [31:0] adr_m2s, dat_m2s;
    logic [1:0]  sel_m2s;
    logic        cyc_m2s, stb_m2s, we_m2s, lok_m2s, running, fault;
    logic [1:0]  last_st;

    xfer_t expQ[$];
    xfer_t obsQ[$];
    int    stampQ[$];
    int    compared = 0;
    int    mismatched = 0;
    int    cycleCount = 0;
    int    stableViol = 0;
    int    lastDur = 0;
    int    ackDelay = 1;
    int    rtyLeft = 0;
    bit    noResp = 0;
    bit    errOnce = 0;
    logic [1:0] stValue = 2'b00;

    iwdg_feeder dut (
        .clk_m2s(clk_m2s), .rst_m2s(rst_m2s), .start(start), .stop(stop),
        .pr_cfg(pr_cfg), .refresh_period(refresh_period),
        .dat_s2m(dat_s2m), .ack_s2m(ack_s2m), .err_s2m(err_s2m), .rty_s2m(rty_s2m),
        .adr_m2s(adr_m2s), .dat_m2s(dat_m2s), .sel_m2s(sel_m2s),
        .cyc_m2s(cyc_m2s), .stb_m2s(stb_m2s), .we_m2s(we_m2s), .lok_m2s(lok_m2s),
        .running(running), .fault(fault), .last_st(last_st)
    );

    initial forever #5 clk_m2s = ~clk_m2s;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic xfer_t mkX(input logic [31:0] adr, input logic [31:0] dat,
                                  input logic we, input logic lok);
        return {adr, dat, we, lok, 2'b11};
    endfunction

    // Slave model and transfer logger, both acting on the falling edge.
    initial begin : slaveMonitor
        int    stbCycles;
        int    dur;
        bit    inXfer;
        xfer_t cur;
        xfer_t nowX;
        stbCycles = 0; dur = 0; inXfer = 0;
        ack_s2m = 1'b0; err_s2m = 1'b0; rty_s2m = 1'b0; dat_s2m = 32'h0;
        forever begin
            @(negedge clk_m2s);
            cycleCount++;
            ack_s2m = 1'b0; err_s2m = 1'b0; rty_s2m = 1'b0; dat_s2m = 32'h0;
            if (cyc_m2s && stb_m2s) begin
                nowX = {adr_m2s, (we_m2s ? dat_m2s : 32'h0), we_m2s, lok_m2s, sel_m2s};
                if (!inXfer) begin
                    inXfer = 1; cur = nowX; dur = 0;
                    obsQ.push_back(nowX);
                    stampQ.push_back(cycleCount);
                end else if (nowX !== cur) begin
                    stableViol++;
                end
                dur++;
                if (!noResp && stbCycles == ackDelay) begin
                    if (errOnce) begin
                        err_s2m = 1'b1; ack_s2m = 1'b1; errOnce = 0;
                    end else if (rtyLeft > 0) begin
                        rty_s2m = 1'b1; rtyLeft--;
                    end else begin
                        ack_s2m = 1'b1; dat_s2m = {30'b0, stValue};
                    end
                end
                stbCycles++;
            end else begin
                if (inXfer) lastDur = dur;
                inXfer = 0; stbCycles = 0;
            end
        end
    end

    task automatic tick();
        @(negedge clk_m2s);
        #1;
    endtask

    task automatic pulseStart();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic pulseStop();
        stop = 1'b1; tick(); stop = 1'b0;
    endtask

    task automatic nextObs(output xfer_t obs, output int stamp, output bit got);
        int budget;
        budget = 200;
        got = 0; obs = 'x; stamp = 0;
        while (obsQ.size() == 0 && budget > 0) begin
            tick();
            budget--;
        end
        if (obsQ.size() > 0) begin
            obs = obsQ.pop_front();
            stamp = stampQ.pop_front();
            got = 1;
        end
    endtask

    task automatic test_reset();
        rst_m2s = 1'b0; start = 1'b0; stop = 1'b0; pr_cfg = 3'd0; refresh_period = 16'd10;
        repeat (3) tick();
        compared++;
        if ({cyc_m2s, stb_m2s, we_m2s, lok_m2s} !== 4'b0000) begin
            mismatched++; $display("[TB] FAIL reset_ctl: got %b want 0000", {cyc_m2s, stb_m2s, we_m2s, lok_m2s});
        end
        compared++;
        if (adr_m2s !== 32'h0 || dat_m2s !== 32'h0) begin
            mismatched++; $display("[TB] FAIL reset_adr_dat: got %h/%h want 0/0", adr_m2s, dat_m2s);
        end
        compared++;
        if (sel_m2s !== 2'b00) begin
            mismatched++; $display("[TB] FAIL reset_sel: got %b want 00", sel_m2s);
        end
        compared++;
        if ({running, fault, last_st} !== 4'b0000) begin
            mismatched++; $display("[TB] FAIL reset_status: got %b want 0000", {running, fault, last_st});
        end
        rst_m2s = 1'b1;
        repeat (3) tick();
        compared++;
        if ({cyc_m2s, running, fault} !== 3'b000) begin
            mismatched++; $display("[TB] FAIL post_reset_idle: got %b want 000", {cyc_m2s, running, fault});
        end
    endtask

    task automatic test_configure();
        xfer_t obs, exp; int st; bit got;
        pr_cfg = 3'd3; refresh_period = 16'd10; stValue = 2'b01; ackDelay = 1;
        expQ.push_back(mkX(BASE, 32'h5555, 1'b1, 1'b1));
        expQ.push_back(mkX(BASE + 32'h4, 32'h3, 1'b1, 1'b1));
        expQ.push_back(mkX(BASE, 32'hCCCC, 1'b1, 1'b1));
        pulseStart();
        pr_cfg = 3'd5;
        for (int i = 0; i < 3; i++) begin
            nextObs(obs, st, got);
            exp = expQ.pop_front();
            compared++;
            if (!got || obs !== exp) begin
                mismatched++; $display("[TB] FAIL cfg_xfer%0d: got %h (seen %0d) want %h", i, obs, got, exp);
            end
        end
        repeat (2) tick();
        compared++;
        if ({running, fault} !== 2'b10) begin
            mismatched++; $display("[TB] FAIL cfg_running: got %b want 10", {running, fault});
        end
    endtask

    task automatic test_refresh();
        xfer_t obs, exp; int st; bit got;
        int stamps[3];
        for (int k = 0; k < 3; k++) begin
            expQ.push_back(mkX(BASE, 32'hAAAA, 1'b1, 1'b0));
            expQ.push_back(mkX(BASE + 32'hC, 32'h0, 1'b0, 1'b0));
            nextObs(obs, st, got);
            exp = expQ.pop_front();
            stamps[k] = st;
            compared++;
            if (!got || obs !== exp) begin
                mismatched++; $display("[TB] FAIL refresh_wr%0d: got %h want %h", k, obs, exp);
            end
            if (k == 1) refresh_period = 16'd0;
            nextObs(obs, st, got);
            exp = expQ.pop_front();
            compared++;
            if (!got || obs !== exp) begin
                mismatched++; $display("[TB] FAIL refresh_rd%0d: got %h want %h", k, obs, exp);
            end
        end
        compared++;
        if (stamps[1] - stamps[0] !== 16) begin
            mismatched++; $display("[TB] FAIL period_10: got %0d want 16 cycles", stamps[1] - stamps[0]);
        end
        compared++;
        if (stamps[2] - stamps[1] !== 7) begin
            mismatched++; $display("[TB] FAIL period_0: got %0d want 7 cycles", stamps[2] - stamps[1]);
        end
        repeat (2) tick();
        compared++;
        if (last_st !== 2'b01) begin
            mismatched++; $display("[TB] FAIL last_st: got %b want 01", last_st);
        end
    endtask

    task automatic test_stop();
        xfer_t obs, exp; int st; bit got;
        refresh_period = 16'd10;
        expQ.push_back(mkX(BASE, 32'hAAAA, 1'b1, 1'b0));
        nextObs(obs, st, got);
        exp = expQ.pop_front();
        pulseStop();
        compared++;
        if (!got || obs !== exp) begin
            mismatched++; $display("[TB] FAIL stop_refresh: got %h want %h", obs, exp);
        end
        expQ.push_back(mkX(BASE + 32'hC, 32'h0, 1'b0, 1'b0));
        nextObs(obs, st, got);
        exp = expQ.pop_front();
        compared++;
        if (!got || obs !== exp) begin
            mismatched++; $display("[TB] FAIL stop_read: got %h want %h", obs, exp);
        end
        repeat (20) tick();
        compared++;
        if (obsQ.size() !== 0 || {running, cyc_m2s} !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL stop_idle: got extra=%0d run/cyc=%b want 0/00", obsQ.size(), {running, cyc_m2s});
        end

        expQ.push_back(mkX(BASE, 32'h5555, 1'b1, 1'b1));
        expQ.push_back(mkX(BASE + 32'h4, 32'h5, 1'b1, 1'b1));
        expQ.push_back(mkX(BASE, 32'hCCCC, 1'b1, 1'b1));
        pulseStart();
        for (int i = 0; i < 3; i++) begin
            nextObs(obs, st, got);
            exp = expQ.pop_front();
            compared++;
            if (!got || obs !== exp) begin
                mismatched++; $display("[TB] FAIL restart_xfer%0d: got %h want %h", i, obs, exp);
            end
        end
        repeat (11) tick();
        compared++;
        if (running !== 1'b1) begin
            mismatched++; $display("[TB] FAIL wait_running: got %b want 1", running);
        end
        pulseStop();
        repeat (30) tick();
        compared++;
        if (obsQ.size() !== 0 || running !== 1'b0) begin
            mismatched++; $display("[TB] FAIL stop_vs_expiry: got extra=%0d running=%b want 0/0", obsQ.size(), running);
        end
    endtask

    task automatic test_retry();
        xfer_t obs, exp; int st; bit got;
        rtyLeft = 3;
        repeat (4) expQ.push_back(mkX(BASE, 32'h5555, 1'b1, 1'b1));
        expQ.push_back(mkX(BASE + 32'h4, 32'h5, 1'b1, 1'b1));
        expQ.push_back(mkX(BASE, 32'hCCCC, 1'b1, 1'b1));
        pulseStart();
        for (int i = 0; i < 6; i++) begin
            nextObs(obs, st, got);
            exp = expQ.pop_front();
            compared++;
            if (!got || obs !== exp) begin
                mismatched++; $display("[TB] FAIL rty3_xfer%0d: got %h want %h", i, obs, exp);
            end
        end
        repeat (3) tick();
        compared++;
        if ({running, fault} !== 2'b10) begin
            mismatched++; $display("[TB] FAIL rty3_status: got %b want 10", {running, fault});
        end
        pulseStop();
        repeat (3) tick();
        compared++;
        if (running !== 1'b0) begin
            mismatched++; $display("[TB] FAIL stop_in_wait: got %b want 0", running);
        end

        rtyLeft = 4;
        repeat (4) expQ.push_back(mkX(BASE, 32'h5555, 1'b1, 1'b1));
        pulseStart();
        for (int i = 0; i < 4; i++) begin
            nextObs(obs, st, got);
            exp = expQ.pop_front();
            compared++;
            if (!got || obs !== exp) begin
                mismatched++; $display("[TB] FAIL rty4_xfer%0d: got %h want %h", i, obs, exp);
            end
        end
        repeat (3) tick();
        compared++;
        if ({fault, running, cyc_m2s, stb_m2s} !== 4'b1000) begin
            mismatched++; $display("[TB] FAIL rty4_fault: got %b want 1000", {fault, running, cyc_m2s, stb_m2s});
        end
        repeat (10) tick();
        compared++;
        if (obsQ.size() !== 0) begin
            mismatched++; $display("[TB] FAIL rty4_quiet: got %0d extra transfers want 0", obsQ.size());
        end
    endtask

    task automatic test_timeout();
        xfer_t obs, exp; int st; bit got;
        noResp = 1;
        expQ.push_back(mkX(BASE, 32'h5555, 1'b1, 1'b1));
        pulseStart();
        compared++;
        if (fault !== 1'b0) begin
            mismatched++; $display("[TB] FAIL fault_clear: got %b want 0", fault);
        end
        nextObs(obs, st, got);
        exp = expQ.pop_front();
        compared++;
        if (!got || obs !== exp) begin
            mismatched++; $display("[TB] FAIL tmo_xfer: got %h want %h", obs, exp);
        end
        repeat (20) tick();
        compared++;
        if ({fault, cyc_m2s} !== 2'b10) begin
            mismatched++; $display("[TB] FAIL tmo_fault: got %b want 10", {fault, cyc_m2s});
        end
        compared++;
        if (lastDur !== 15) begin
            mismatched++; $display("[TB] FAIL tmo_length: got %0d want 15 cycles", lastDur);
        end
        noResp = 0;
        pr_cfg = 3'd6;
        expQ.push_back(mkX(BASE, 32'h5555, 1'b1, 1'b1));
        expQ.push_back(mkX(BASE + 32'h4, 32'h6, 1'b1, 1'b1));
        expQ.push_back(mkX(BASE, 32'hCCCC, 1'b1, 1'b1));
        pulseStart();
        for (int i = 0; i < 3; i++) begin
            nextObs(obs, st, got);
            exp = expQ.pop_front();
            compared++;
            if (!got || obs !== exp) begin
                mismatched++; $display("[TB] FAIL recover_xfer%0d: got %h want %h", i, obs, exp);
            end
        end
        repeat (2) tick();
        compared++;
        if ({running, fault} !== 2'b10) begin
            mismatched++; $display("[TB] FAIL recover_status: got %b want 10", {running, fault});
        end
    endtask

    task automatic test_error();
        xfer_t obs, exp; int st; bit got;
        errOnce = 1;
        expQ.push_back(mkX(BASE, 32'hAAAA, 1'b1, 1'b0));
        nextObs(obs, st, got);
        exp = expQ.pop_front();
        compared++;
        if (!got || obs !== exp) begin
            mismatched++; $display("[TB] FAIL err_xfer: got %h want %h", obs, exp);
        end
        repeat (3) tick();
        compared++;
        if ({fault, running, cyc_m2s} !== 3'b100) begin
            mismatched++; $display("[TB] FAIL err_fault: got %b want 100", {fault, running, cyc_m2s});
        end
    endtask

    task automatic test_reset_mid();
        xfer_t obs, exp; int st; bit got;
        expQ.push_back(mkX(BASE, 32'h5555, 1'b1, 1'b1));
        expQ.push_back(mkX(BASE + 32'h4, 32'h6, 1'b1, 1'b1));
        pulseStart();
        for (int i = 0; i < 2; i++) begin
            nextObs(obs, st, got);
            exp = expQ.pop_front();
            compared++;
            if (!got || obs !== exp) begin
                mismatched++; $display("[TB] FAIL rstmid_xfer%0d: got %h want %h", i, obs, exp);
            end
        end
        #2;
        rst_m2s = 1'b0;
        #1;
        compared++;
        if ({cyc_m2s, stb_m2s} !== 2'b00) begin
            mismatched++; $display("[TB] FAIL rstmid_async: got %b want 00", {cyc_m2s, stb_m2s});
        end
        compared++;
        if (adr_m2s !== 32'h0 || dat_m2s !== 32'h0 || sel_m2s !== 2'b00 || {we_m2s, lok_m2s} !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL rstmid_bus: got adr=%h dat=%h sel=%b we/lok=%b want zeros", adr_m2s, dat_m2s, sel_m2s, {we_m2s, lok_m2s});
        end
        compared++;
        if ({running, fault, last_st} !== 4'b0000) begin
            mismatched++; $display("[TB] FAIL rstmid_status: got %b want 0000", {running, fault, last_st});
        end
        tick();
        rst_m2s = 1'b1;
        repeat (3) tick();
        compared++;
        if ({cyc_m2s, running, fault} !== 3'b000) begin
            mismatched++; $display("[TB] FAIL rstmid_release: got %b want 000", {cyc_m2s, running, fault});
        end
        obsQ.delete(); stampQ.delete(); expQ.delete();
    endtask

    initial begin
        test_reset();
        test_configure();
        test_refresh();
        test_stop();
        test_retry();
        test_timeout();
        test_error();
        test_reset_mid();
        compared++;
        if (stableViol !== 0) begin
            mismatched++; $display("[TB] FAIL bus_stable: got %0d changes mid-transfer want 0", stableViol);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
